audio_out_fifo: RTL
===================

Name: audio_out_fifo

Overview:
- Buffers decoded 32-bit audio words ({left[15:0], right[15:0]}) between the packet decoder and the I2S serializer.
- Paces the host through one-cycle sample-request pulses, which feed the outgoing packet encoder.
- Handles start, stop, priming and underflow so the serializer never stalls.
- Lives entirely in the mon_clk domain.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two.
- AW, 4, log2(DEPTH).
- LOW_WATER, 4, level at or below which a new request is issued.
- START_LEVEL, 8, level needed to leave PRIME.
- BURST, 4, words expected per request.
- REQ_TIMEOUT, 4095, cycles before an unanswered request is abandoned.
- TO_W, 12, timeout counter width.

Ports:
- mon_clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- audio_start, in, 1: one-cycle pulse; begin or restart playback.
- audio_stop, in, 1: one-cycle pulse; end playback.
- wr_valid, in, 1: one-cycle strobe; wr_data is valid.
- wr_data, in, 32: audio word.
- rd_req, in, 1: one-cycle pulse from the serializer, once per stereo frame.
- rd_data, out, 32: sample for the serializer.
- rd_valid, out, 1: rd_data is valid.
- audio_req, out, 1: one-cycle request pulse to the encoder.
- level, out, AW+1: current occupancy, 0..DEPTH.
- playing, out, 1: high in RUN.
- underflow, out, 1: one-cycle pulse per underflow event.
- overflow, out, 1: one-cycle pulse per dropped write.
- underflow_count, out, 8: saturating event count.

Behaviour:
- Reset:
  - State IDLE; read and write pointers 0; level 0.
  - All outputs 0; request engine idle.
  - Reset applies on the next edge, even mid-burst or mid-read.
- States:
  - IDLE: writes are dropped silently (no overflow pulse). Reads return zero. No requests.
  - PRIME: writes are accepted. Reads return zero without popping. Requests are issued whenever none is pending and level < START_LEVEL.
  - RUN: writes are accepted. Reads pop the FIFO. Requests are issued whenever none is pending and level <= LOW_WATER.
- Transitions:
  - Any state -> PRIME on audio_start. The FIFO is flushed, underflow_count cleared and any pending request cancelled.
  - Any state -> IDLE on audio_stop. The FIFO is flushed and the pending request cancelled.
  - If audio_start and audio_stop arrive in the same cycle, stop wins.
  - PRIME -> RUN when level >= START_LEVEL, evaluated on the registered level.
  - RUN -> PRIME on an underflow.
- Write path:
  - Accepted if not full, or if full and a pop happens in the same cycle.
  - Otherwise the word is dropped, with an overflow pulse in the next cycle.
- Read path, latency 1:
  - rd_req in cycle N gives rd_valid=1 in cycle N+1 for exactly one cycle.
  - rd_data is held until the next rd_valid.
  - In RUN with level > 0: rd_data = head word, and the entry is popped.
  - In RUN with level = 0: rd_data = 0, plus underflow pulse, underflow_count+1 (saturating at 255), next state PRIME.
  - Emptiness is judged on the pre-edge level. A simultaneous write into an empty FIFO is still accepted, but the read underflows.
- Level:
  - Increments on a write only, decrements on a pop only, unchanged on both.
  - Pointers wrap modulo DEPTH.
- Request engine:
  - When the issue condition holds and nothing is pending, audio_req pulses in the next cycle.
  - On issue: pending=1, credits=BURST, timer=REQ_TIMEOUT.
  - Each accepted write while pending decrements credits. Pending clears when credits reaches 0 or the timer reaches 0.
  - The earliest re-issue is the cycle after pending clears, so there is never more than one request in flight.
  - Writes beyond the credits are accepted normally; credits floor at 0.
- playing equals (state == RUN), registered.

Test Plan:
- Reset, then audio_start:
  - audio_req pulses once at cycle 2.
  - Feed 4 words -> pending clears; a second audio_req follows.
  - After 8 words -> playing=1, level=8.
- In RUN at level=8, pulse rd_req 4 times:
  - rd_valid follows each rd_req by 1 cycle with words in write order.
  - level reaches 4 -> audio_req pulses once.
- Drain to 0, then issue rd_req:
  - rd_data=0, underflow pulse, underflow_count=1, playing=0.
  - No pop; level stays 0.
- Fill to 16, then apply wr_valid alone:
  - overflow pulse; level stays 16; the dropped word never appears on rd_data.
- At level=16, apply wr_valid and rd_req in the same cycle:
  - Write accepted, no overflow, level stays 16.
- Issue a request and supply no writes:
  - pending is abandoned after 4095 cycles; audio_req re-pulses on the next cycle.
- Apply audio_start and audio_stop together mid-RUN:
  - Next state IDLE, level=0.
- Assert reset mid-burst:
  - All outputs 0 after one edge.

Source files
------------

// File: rtl/audio_out_fifo.sv
// Playback buffer between the packet decoder and the I2S serializer; paces the
// host with one-cycle sample requests and recovers from underflow by re-priming.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | stopped: writes dropped silently, reads return zero, no requests
// ST_PRIME | filling: writes accepted, reads return zero without popping
// ST_RUN   | playing: reads pop the FIFO, refill requested at low water
module audio_out_fifo #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int LOW_WATER   = 4,
  parameter int START_LEVEL = 8,
  parameter int BURST       = 4,
  parameter int REQ_TIMEOUT = 4095,
  parameter int TO_W        = 12
) (
  input  logic          i_mon_clk,
  input  logic          i_reset,
  input  logic          i_audio_start,
  input  logic          i_audio_stop,
  input  logic          i_wr_valid,
  input  logic [31:0]   i_wr_data,
  input  logic          i_rd_req,
  output logic [31:0]   o_rd_data,
  output logic          o_rd_valid,
  output logic          o_audio_req,
  output logic [AW:0]   o_level,
  output logic          o_playing,
  output logic          o_underflow,
  output logic          o_overflow,
  output logic [7:0]    o_underflow_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_t;

  localparam int CW = $clog2(BURST + 1);
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   START_LVL = (AW+1)'(START_LEVEL);
  localparam logic [AW:0]   LOW_LVL   = (AW+1)'(LOW_WATER);
  localparam logic [CW-1:0] BURST_CR  = CW'(BURST);
  localparam logic [TO_W-1:0] TO_INIT = TO_W'(REQ_TIMEOUT);

  state_t          r_state;
  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;
  logic [31:0]     r_rd_data;
  logic            r_rd_valid;
  logic            r_audio_req;
  logic            r_playing;
  logic            r_underflow;
  logic            r_overflow;
  logic [7:0]      r_uf_count;
  logic            r_pending;
  logic [CW-1:0]   r_credits;
  logic [TO_W-1:0] r_timer;

  logic   w_flush;
  logic   w_full;
  logic   w_empty;
  logic   w_active;
  logic   w_pop;
  logic   w_uflow;
  logic   w_wr_ok;
  logic   w_wr_drop;
  logic   w_issue;
  state_t w_next_state;

  // Start/stop flush the FIFO, so a word or read arriving with them is discarded.
  assign w_flush   = i_audio_start | i_audio_stop;
  assign w_full    = (r_level == FULL_LVL);
  assign w_empty   = (r_level == '0);
  assign w_active  = !w_flush && (r_state != ST_IDLE);
  assign w_pop     = !w_flush && (r_state == ST_RUN) && i_rd_req && !w_empty;
  assign w_uflow   = !w_flush && (r_state == ST_RUN) && i_rd_req && w_empty;
  assign w_wr_ok   = w_active && i_wr_valid && (!w_full || w_pop);
  assign w_wr_drop = w_active && i_wr_valid && w_full && !w_pop;
  assign w_issue   = !w_flush && !r_pending &&
                     (((r_state == ST_PRIME) && (r_level < START_LVL)) ||
                      ((r_state == ST_RUN) && (r_level <= LOW_LVL)));

  always_comb begin
    w_next_state = r_state;
    if (i_audio_stop) begin
      w_next_state = ST_IDLE;
    end else if (i_audio_start) begin
      w_next_state = ST_PRIME;
    end else begin
      case (r_state)
        ST_PRIME: if (r_level >= START_LVL) w_next_state = ST_RUN;
        ST_RUN:   if (w_uflow) w_next_state = ST_PRIME;
        default:  w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge i_mon_clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_mon_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_audio_req <= 1'b0;
      r_playing   <= 1'b0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
      r_uf_count  <= '0;
      r_pending   <= 1'b0;
      r_credits   <= '0;
      r_timer     <= '0;
    end else begin
      r_state     <= w_next_state;
      r_playing   <= (w_next_state == ST_RUN);
      r_rd_valid  <= i_rd_req;
      r_underflow <= w_uflow;
      r_overflow  <= w_wr_drop;
      r_audio_req <= w_issue;
      if (i_rd_req) r_rd_data <= w_pop ? r_mem[r_rd_ptr] : '0;

      if (i_audio_start && !i_audio_stop) begin
        r_uf_count <= '0;
      end else if (w_uflow && (r_uf_count != 8'hFF)) begin
        r_uf_count <= r_uf_count + 1'b1;
      end

      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_wr_ok && !w_pop)      r_level <= r_level + 1'b1;
        else if (w_pop && !w_wr_ok) r_level <= r_level - 1'b1;
      end

      // One request in flight: it retires on its last credited word or on timeout.
      if (w_flush) begin
        r_pending <= 1'b0;
        r_credits <= '0;
        r_timer   <= '0;
      end else if (w_issue) begin
        r_pending <= 1'b1;
        r_credits <= BURST_CR;
        r_timer   <= TO_INIT;
      end else if (r_pending) begin
        r_timer <= r_timer - 1'b1;
        if (w_wr_ok && (r_credits != '0)) r_credits <= r_credits - 1'b1;
        if ((w_wr_ok && (r_credits <= CW'(1))) || (r_timer <= TO_W'(1)))
          r_pending <= 1'b0;
      end
    end
  end

  assign o_rd_data         = r_rd_data;
  assign o_rd_valid        = r_rd_valid;
  assign o_audio_req       = r_audio_req;
  assign o_level           = r_level;
  assign o_playing         = r_playing;
  assign o_underflow       = r_underflow;
  assign o_overflow        = r_overflow;
  assign o_underflow_count = r_uf_count;

endmodule
